// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: fetches a 4-word tile from memory, streams it into the input buffer, launches compute.
// Defining IFETCH_PERF_EN adds the 16-bit completed-tile counter output TILE_CNT.
module ifetch_ctrl #(
    parameter int WAIT_CYCLES = 7,
    parameter int AW          = 8
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          START,
    input  logic [AW-1:0] BASE_ADDR,
    input  logic [3:0]    ODST_IN,
    output logic          MEM_RD_EN,
    output logic [AW-1:0] MEM_ADDR,
    input  logic [31:0]   MEM_RDATA,
    output logic          LOAD_EN,
    output logic [1:0]    ICOL,
    output logic [31:0]   IWord,
    output logic [3:0]    ODST,
    output logic          START_CALC,
    output logic          BUSY,
`ifdef IFETCH_PERF_EN
    output logic          DONE,
    output logic [15:0]   TILE_CNT
`else
    output logic          DONE
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, LAUNCH, WAIT} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [3:0]    odst_q, odst_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [1:0]    icol_q, icol_d;
    logic          load_q, load_d;
    logic          done_q, done_d;
    logic          rd_en;
    // FETCH spans five cycles: four reads, then one cycle letting the last word land
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        odst_d  = odst_q;
        cnt_d   = cnt_q + 8'd1;
        done_d  = 1'b0;
        rd_en   = (state_q == FETCH) && !cnt_q[2];
        load_d  = rd_en;
        icol_d  = rd_en ? cnt_q[1:0] : 2'd0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (START) begin
                    state_d = FETCH;
                    base_d  = BASE_ADDR;
                    odst_d  = ODST_IN;
                end
            end
            FETCH:  state_d = cnt_q[2] ? LAUNCH : FETCH;
            LAUNCH: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (cnt_q == 8'(WAIT_CYCLES - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            base_q  <= '0;
            odst_q  <= '0;
            cnt_q   <= '0;
            icol_q  <= '0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            odst_q  <= odst_d;
            cnt_q   <= cnt_d;
            icol_q  <= icol_d;
            load_q  <= load_d;
            done_q  <= done_d;
        end
    end
    assign MEM_RD_EN  = rd_en;
    assign MEM_ADDR   = rd_en ? base_q + AW'(cnt_q[1:0]) : '0;
    assign LOAD_EN    = load_q;
    assign ICOL       = icol_q;
    assign ODST       = load_q ? odst_q : 4'd0;
    assign IWord      = MEM_RDATA;
    assign START_CALC = (state_q == LAUNCH);
    assign BUSY       = (state_q != IDLE);
    assign DONE       = done_q;
`ifdef IFETCH_PERF_EN
    logic [15:0] tile_cnt_q, tile_cnt_d;
    always_comb tile_cnt_d = done_q ? tile_cnt_q + 16'd1 : tile_cnt_q;
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) tile_cnt_q <= '0;
        else       tile_cnt_q <= tile_cnt_d;
    end
    assign TILE_CNT = tile_cnt_q;
`endif
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: scoreboard bench; a tile-level model queues expected events, a monitor pops and compares.
module tb_ifetch_ctrl;
    localparam int W = 7;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b1;
    logic        START = 1'b0;
    logic [7:0]  BASE_ADDR = '0;
    logic [3:0]  ODST_IN = '0;
    logic [31:0] MEM_RDATA = '0;
    logic        MEM_RD_EN, LOAD_EN, START_CALC, BUSY, DONE;
    logic [7:0]  MEM_ADDR;
    logic [1:0]  ICOL;
    logic [31:0] IWord;
    logic [3:0]  ODST;
`ifdef IFETCH_PERF_EN
    logic [15:0] TILE_CNT;
    int          exp_tc = 0;
`endif

    ifetch_ctrl #(.WAIT_CYCLES(W), .AW(8)) dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .BASE_ADDR(BASE_ADDR), .ODST_IN(ODST_IN),
        .MEM_RD_EN(MEM_RD_EN), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA),
        .LOAD_EN(LOAD_EN), .ICOL(ICOL), .IWord(IWord), .ODST(ODST),
        .START_CALC(START_CALC), .BUSY(BUSY),
`ifdef IFETCH_PERF_EN
        .TILE_CNT(TILE_CNT),
`endif
        .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {int cyc; logic [7:0] addr;} rd_t;
    typedef struct {int cyc; logic [1:0] icol; logic [31:0] word; logic [3:0] odst;} ld_t;
    rd_t rd_q[$];
    ld_t ld_q[$];
    int  calc_q[$];
    int  done_q[$];
    int  cyc = 0, free_at = 0, busy_lo = 0, busy_hi = -1;
    int  errors = 0, checks = 0;

    function automatic logic [31:0] mem(input logic [7:0] a);
        return 32'hA0B0C000 + 32'(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model: an accepted START at cycle c yields reads c+1..c+4, loads c+2..c+5,
    // launch c+6, done c+7+W; a new START is accepted only from the DONE cycle onward.
    always @(posedge CLK) begin
        MEM_RDATA <= MEM_RD_EN ? mem(MEM_ADDR) : $urandom;
        if (RSTN && START && cyc >= free_at) begin
            for (int i = 0; i < 4; i++) begin
                rd_q.push_back('{cyc + 1 + i, 8'(BASE_ADDR + i)});
                ld_q.push_back('{cyc + 2 + i, 2'(i), mem(8'(BASE_ADDR + i)), ODST_IN});
            end
            calc_q.push_back(cyc + 6);
            done_q.push_back(cyc + 7 + W);
            busy_lo = cyc + 1;
            busy_hi = cyc + 6 + W;
            free_at = cyc + 7 + W;
        end
        cyc++;
    end

    always @(negedge CLK) begin
        bit e;
        e = rd_q.size() > 0 && rd_q[0].cyc == cyc;
        if (e || MEM_RD_EN) begin
            chk("mem_rd_en", 32'(MEM_RD_EN), 32'(e));
            if (e) begin
                chk("mem_addr", 32'(MEM_ADDR), 32'(rd_q[0].addr));
                void'(rd_q.pop_front());
            end
        end
        e = ld_q.size() > 0 && ld_q[0].cyc == cyc;
        if (e || LOAD_EN) begin
            chk("load_en", 32'(LOAD_EN), 32'(e));
            if (e) begin
                chk("icol", 32'(ICOL), 32'(ld_q[0].icol));
                chk("iword", IWord, ld_q[0].word);
                chk("odst", 32'(ODST), 32'(ld_q[0].odst));
                void'(ld_q.pop_front());
            end
        end
        if (!LOAD_EN) chk("idle_icol_odst", 32'({ICOL, ODST}), 32'd0);
        e = calc_q.size() > 0 && calc_q[0] == cyc;
        if (e || START_CALC) begin
            chk("start_calc", 32'(START_CALC), 32'(e));
            if (e) void'(calc_q.pop_front());
        end
        e = done_q.size() > 0 && done_q[0] == cyc;
        if (e || DONE) begin
            chk("done", 32'(DONE), 32'(e));
            if (e) void'(done_q.pop_front());
        end
`ifdef IFETCH_PERF_EN
        chk("tile_cnt", 32'(TILE_CNT), 32'(exp_tc[15:0]));
        if (e) exp_tc++;
`endif
        chk("busy", 32'(BUSY), 32'(cyc >= busy_lo && cyc <= busy_hi));
    end

    task automatic do_reset();
        @(negedge CLK);
        START = 1'b0;
        #2 RSTN = 1'b0;
        #1;
        chk("reset_outputs", 32'({MEM_RD_EN, MEM_ADDR, LOAD_EN, ICOL, ODST, START_CALC, BUSY, DONE}), 32'd0);
        chk("reset_iword", IWord, MEM_RDATA);
        rd_q.delete();
        ld_q.delete();
        calc_q.delete();
        done_q.delete();
        busy_hi = -1;
        free_at = 0;
`ifdef IFETCH_PERF_EN
        exp_tc = 0;
`endif
        repeat (2) @(negedge CLK);
        #2 RSTN = 1'b1;
    endtask

    task automatic tile(input logic [7:0] b, input logic [3:0] o);
        @(negedge CLK);
        START = 1'b1;
        BASE_ADDR = b;
        ODST_IN = o;
        @(negedge CLK);
        START = 1'b0;
        repeat (W + 10) @(negedge CLK);
    endtask

    initial begin
        #3 RSTN = 1'b0;
        do_reset();
        tile(8'h10, 4'h5);
        @(negedge CLK);
        START = 1'b1; BASE_ADDR = 8'h10; ODST_IN = 4'h5;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        START = 1'b1; BASE_ADDR = 8'h40; ODST_IN = 4'h9;
        @(negedge CLK);
        START = 1'b0;
        repeat (W + 10) @(negedge CLK);
        tile(8'hFE, 4'h3);
        @(negedge CLK);
        START = 1'b1; BASE_ADDR = 8'h20; ODST_IN = 4'h7;
        repeat (2 * (7 + W) + 2) @(negedge CLK);
        START = 1'b0;
        repeat (2 * (7 + W)) @(negedge CLK);
        @(negedge CLK);
        START = 1'b1; BASE_ADDR = 8'h30; ODST_IN = 4'hC;
        @(negedge CLK);
        START = 1'b0;
        do_reset();
        repeat (W + 12) @(negedge CLK);
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            @(negedge CLK);
            START = ($urandom_range(3) == 0);
            BASE_ADDR = 8'($urandom);
            ODST_IN = 4'($urandom);
        end
        @(negedge CLK);
        START = 1'b0;
        repeat (W + 12) @(negedge CLK);
        chk("queues_drained", 32'(rd_q.size() + ld_q.size() + calc_q.size() + done_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
